aes_round_iter: RTL
===================

Name: aes_round_iter

Overview:
Iterative AES encryption round engine. It holds the 128-bit cipher state register and drives the subbyte block, which is instantiated alongside it at the same level. It consumes the subbyte output and applies ShiftRows, MixColumns and AddRoundKey, one round per clock. Round keys come from an external key-schedule store, indexed by a round-index output; the block sits between the input block buffer and the ciphertext output stage.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256); final round omits MixColumns.
RK_IDX_W, 4, width of round-key index; must hold 0..NR.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  plaintext block offered
in_ready  out  1  engine can accept a block
in_data  in  128  plaintext; byte i at [8*i+7:8*i], byte 0 = first FIPS-197 byte (column i/4, row i%4)
out_valid  out  1  ciphertext available
out_ready  in  1  downstream accepts ciphertext
out_data  out  128  ciphertext, same byte ordering
rk_idx  out  RK_IDX_W  round-key index requested this cycle
rk  in  128  round key for rk_idx, valid combinationally same cycle
sb_in  out  128  state driven to external subbyte
sb_out  in  128  subbyte result of sb_in, combinational

Behaviour:
- FSM states: IDLE, ROUND, DONE. Reset: state IDLE, round counter 0, state register 0, in_ready=1, out_valid=0, rk_idx=0, sb_in=0, out_data=0.
- IDLE: in_ready=1; rk_idx=0. On in_valid: state <= in_data ^ rk; counter <= 1; go to ROUND.
- ROUND: in_ready=0; rk_idx=counter; sb_in=state register.
  - If counter<NR: state <= MixColumns(ShiftRows(sb_out)) ^ rk; counter++.
  - If counter==NR: state <= ShiftRows(sb_out) ^ rk; go to DONE.
- DONE: out_valid=1, out_data=state register, in_ready=0. When out_ready is high: go to IDLE, counter <= 0.
- out_data is held stable while out_valid && !out_ready.
- Latency: a block accepted in cycle T has out_valid high in cycle T+NR+1. Throughput is one block per NR+2 cycles with no backpressure.
- The engine does not overlap blocks. A new block is accepted only in IDLE, so the cycle after an out handshake.
- sb_in is the state register, not a mux. The subbyte path is registered-input combinational; one S-box pass per cycle.
- ShiftRows: output row r, column c = input row r, column (c+r) mod 4.
- MixColumns: GF(2^8) with xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0). Per column: [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
- rk_idx is combinational from FSM/counter. The key store must return rk the same cycle.
- In the outputs-while-idle phase, sb_in follows the state register (don't-care for subbyte).
- in_valid while not in IDLE: ignored, no side effects.
- rst mid-ROUND or in DONE: block discarded; all outputs return to reset values next cycle; no partial output ever asserts out_valid.
- The counter never exceeds NR; no wrap.

Decomposition:
- Shared package aes_pkg: state_t (16x8 byte array) and packing conventions, NR constants (AES128_NR=10, AES192_NR=12, AES256_NR=14), function xtime, function shift_rows.
- One sub-module, mixcolumns (combinational 128->128, four column instances). It is also reused by any later decrypt/verify path.
- Subbyte is instantiated outside this block and connected via sb_in/sb_out.

Test Plan:
- FIPS-197 C.1: key 000102..0f (rk from reference model), in_data=128'hffeeddccbbaa99887766554433221100 -> out_valid after 11 cycles, out_data=128'h5ac5b47080b7cdd830047b6ad8e0c469 (ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a).
- Backpressure: out_ready low 5 cycles in DONE -> out_valid and out_data stable for those cycles, in_ready=0; release -> in_ready=1 next cycle.
- Back-to-back: in_valid held high with 3 random blocks and out_ready=1 -> each accepted 12 cycles apart; outputs match the model in order.
- Busy ignore: pulse in_valid with a different block at counter=4 -> no effect; first ciphertext correct; the second block is not captured.
- Reset mid-operation: assert rst at counter=6 -> next cycle IDLE, in_ready=1, out_valid=0, rk_idx=0; the next block encrypts correctly.
- rk_idx sequence: during one block, rk_idx reads 0,1,...,10, one per cycle, then holds 10 in DONE.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round-count constants and byte-level helpers
//
// Packing: byte i of a 128-bit block sits at [8*i+7:8*i]; byte 0 is the first
// FIPS-197 byte, i.e. column i/4, row i%4.
package aes_pkg;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    // 16 bytes, index = 4*column + row
    typedef logic [15:0][7:0] state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Output row r, column c takes input row r, column (c+r) mod 4
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4*c + r] = s[4*((c + r) % 4) + r];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/mixcolumns.sv
// rtl/mixcolumns.sv - combinational AES MixColumns over a full 128-bit state
//
// Ports:
//   din  [127:0]  state before MixColumns (aes_pkg byte packing)
//   dout [127:0]  state after MixColumns
module mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    // One independent column mixer per column; matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        assign a0 = din[32*c +  0 +: 8];
        assign a1 = din[32*c +  8 +: 8];
        assign a2 = din[32*c + 16 +: 8];
        assign a3 = din[32*c + 24 +: 8];

        // 3*b is xtime(b) ^ b
        assign dout[32*c +  0 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[32*c +  8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes_round_iter.sv
// rtl/aes_round_iter.sv - iterative AES encryption engine, one round per clock
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   plaintext handshake, in_data[127:0]
//   out_valid/out_ready ciphertext handshake, out_data[127:0]
//   rk_idx              round-key index requested this cycle (combinational)
//   rk[127:0]           round key for rk_idx, returned the same cycle
//   sb_in/sb_out        state to / SubBytes result from the external subbyte block
module aes_round_iter
    import aes_pkg::*;
#(
    parameter int NR       = AES128_NR,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk,
    output logic [127:0]        sb_in,
    input  logic [127:0]        sb_out
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NR);

    fsm_t                fsm;
    logic [RK_IDX_W-1:0] cnt;
    logic [127:0]        st;
    logic [127:0]        sr;
    logic [127:0]        mc;

    assign sr = shift_rows(sb_out);

    mixcolumns u_mixcolumns (
        .din  (sr),
        .dout (mc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            cnt <= '0;
            st  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    // rk_idx is 0 here, so rk is the initial whitening key
                    if (in_valid) begin
                        st  <= in_data ^ rk;
                        cnt <= RK_IDX_W'(1);
                        fsm <= ROUND;
                    end
                end
                ROUND: begin
                    if (cnt == LAST_RND) begin
                        // Final round has no MixColumns; counter parks at NR
                        st  <= sr ^ rk;
                        fsm <= DONE;
                    end else begin
                        st  <= mc ^ rk;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        cnt <= '0;
                        fsm <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end

    // All outputs decode straight from registers; the state register feeds
    // both the subbyte block and the ciphertext port without muxing.
    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign out_data  = st;
    assign sb_in     = st;
    assign rk_idx    = (fsm == IDLE) ? '0 : cnt;

endmodule
